// File: rtl/led_seq_pkg.sv
// Shared types and constants for the AXI4-Lite LED sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum (ST_INIT is used only when LED_SEQ_TRI_INIT_EN is defined),
// pattern mode enum, AXI GPIO register offsets, AXI response code and an address helper.
package led_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2,
      ST_INIT = 2'd3
   } state_e;

   typedef enum logic {
      MODE_WALK  = 1'b0,
      MODE_COUNT = 1'b1
   } mode_e;

   localparam logic [8:0] GPIO_DATA_OFFSET = 9'h000;
   localparam logic [8:0] GPIO_TRI_OFFSET  = 9'h004;
   localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

   function automatic logic [31:0] gpio_addr(input logic [31:0] base, input logic [8:0] off);
      return base + {23'd0, off};
   endfunction

endpackage

// File: rtl/led_seq_tick_gen.sv
// Tick divider: raises a one-deep pending request every TICK_DIV enabled cycles.
// Latency: pending sets on the edge that ends the terminal-count cycle.
// Backpressure: one tick queued; a further terminal count while pending sets sticky overrun.
//
// Ports: i_clk/i_rst_n clock and async active-low reset, i_enable run/stop,
// i_consume clears pending (the FSM took the tick), o_pending queued tick, o_overrun sticky.
module led_seq_tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_enable,
   input  logic i_consume,
   output logic o_pending,
   output logic o_overrun
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] r_cnt;
   logic          r_pending;
   logic          r_overrun;
   logic          w_tc;

   assign w_tc      = i_enable && (r_cnt == CW'(TICK_DIV - 1));
   assign o_pending = r_pending;
   assign o_overrun = r_overrun;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (!i_enable || w_tc)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CW'(1);

         // A new tick wins over a same-cycle consume, so the fresh tick stays queued.
         if (!i_enable)
            r_pending <= 1'b0;
         else if (w_tc)
            r_pending <= 1'b1;
         else if (i_consume)
            r_pending <= 1'b0;

         if (w_tc && r_pending && !i_consume)
            r_overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_lite_led_sequencer.sv
// AXI4-Lite write master that writes a walking-one or binary-count LED pattern to AXI GPIO per tick.
// Latency: awvalid/wvalid rise one edge after pending; done pulses on the edge that accepts bvalid.
// Backpressure: AW/W held until each handshake; bready only in RESP; extra ticks flag overrun.
//
// Ports: s_axi_aclk/s_axi_aresetn clock and async active-low reset; enable run/stop; mode
// 0=walking-one 1=count; m_axi_lite_ch1_* AXI4-Lite write channels; done completion pulse;
// status {err, overrun, 6'b0, last pattern[7:0], write count[15:0]}.
// Build option: define LED_SEQ_TRI_INIT_EN to write 0 to the GPIO tri-state register once after reset.
module axi_lite_led_sequencer
   import led_seq_pkg::*;
#(
   parameter int          TICK_DIV  = 100_000_000,
   parameter logic [31:0] GPIO_BASE = 32'h0000_0000,
   parameter int          GPIO_W    = 8
) (
   input  logic        s_axi_aclk,
   input  logic        s_axi_aresetn,
   input  logic        enable,
   input  logic        mode,
   output logic [31:0] m_axi_lite_ch1_awaddr,
   output logic [2:0]  m_axi_lite_ch1_awprot,
   output logic        m_axi_lite_ch1_awvalid,
   input  logic        m_axi_lite_ch1_awready,
   output logic [31:0] m_axi_lite_ch1_wdata,
   output logic [3:0]  m_axi_lite_ch1_wstrb,
   output logic        m_axi_lite_ch1_wvalid,
   input  logic        m_axi_lite_ch1_wready,
   input  logic [1:0]  m_axi_lite_ch1_bresp,
   input  logic        m_axi_lite_ch1_bvalid,
   output logic        m_axi_lite_ch1_bready,
   output logic        done,
   output logic [31:0] status
);

`ifdef LED_SEQ_TRI_INIT_EN
   localparam state_e RST_STATE = ST_INIT;
`else
   localparam state_e RST_STATE = ST_IDLE;
`endif

   state_e            r_state;
   logic [GPIO_W-1:0] r_pattern;
   logic [31:0]       r_awaddr;
   logic [31:0]       r_wdata;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_bready;
   logic              r_done;
   logic              r_err;
   logic [7:0]        r_last_pat;
   logic [15:0]       r_count;

   logic [GPIO_W-1:0] w_next_pat;
   logic              w_pending;
   logic              w_overrun;
   logic              w_consume;
   logic              w_aw_ok;
   logic              w_w_ok;

   led_seq_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .i_clk     (s_axi_aclk),
      .i_rst_n   (s_axi_aresetn),
      .i_enable  (enable),
      .i_consume (w_consume),
      .o_pending (w_pending),
      .o_overrun (w_overrun)
   );

   // Gating on enable keeps a tick that raced with enable falling from being issued.
   assign w_consume = (r_state == ST_IDLE) && w_pending && enable;

   // A channel is finished when its valid is already down or its handshake happens this edge.
   assign w_aw_ok = !r_awvalid || m_axi_lite_ch1_awready;
   assign w_w_ok  = !r_wvalid  || m_axi_lite_ch1_wready;

   // Shift-or rotate form stays legal for GPIO_W == 1 (rotation is then the identity).
   always_comb begin
      w_next_pat = r_pattern + GPIO_W'(1);
      if (mode_e'(mode) == MODE_WALK) begin
         if (r_pattern == '0)
            w_next_pat = GPIO_W'(1);
         else
            w_next_pat = (r_pattern << 1) | (r_pattern >> (GPIO_W - 1));
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state    <= RST_STATE;
         r_pattern  <= '0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_last_pat <= '0;
         r_count    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
`ifdef LED_SEQ_TRI_INIT_EN
            ST_INIT: begin
               // One-time tri-state write: all GPIO pins become outputs before any pattern.
               if (enable) begin
                  r_awaddr  <= gpio_addr(GPIO_BASE, GPIO_TRI_OFFSET);
                  r_wdata   <= '0;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_state   <= ST_ADDR;
               end
            end
`endif
            ST_IDLE: begin
               if (w_consume) begin
                  r_pattern <= w_next_pat;
                  r_awaddr  <= gpio_addr(GPIO_BASE, GPIO_DATA_OFFSET);
                  r_wdata   <= 32'(w_next_pat);
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_state   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_axi_lite_ch1_awready)
                  r_awvalid <= 1'b0;
               if (m_axi_lite_ch1_wready)
                  r_wvalid <= 1'b0;
               if (w_aw_ok && w_w_ok) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (m_axi_lite_ch1_bvalid) begin
                  r_bready   <= 1'b0;
                  r_done     <= 1'b1;
                  r_count    <= r_count + 16'd1;
                  r_last_pat <= r_wdata[7:0];
                  if (m_axi_lite_ch1_bresp != AXI_RESP_OKAY)
                     r_err <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m_axi_lite_ch1_awaddr  = r_awaddr;
   assign m_axi_lite_ch1_awprot  = 3'b000;
   assign m_axi_lite_ch1_awvalid = r_awvalid;
   assign m_axi_lite_ch1_wdata   = r_wdata;
   assign m_axi_lite_ch1_wstrb   = 4'hF;
   assign m_axi_lite_ch1_wvalid  = r_wvalid;
   assign m_axi_lite_ch1_bready  = r_bready;
   assign done                   = r_done;
   assign status                 = {r_err, w_overrun, 6'd0, r_last_pat, r_count};

endmodule

// File: doc/axi_lite_led_sequencer.md
# axi_lite_led_sequencer

AXI4-Lite write master that generates LED patterns and drives them into the AXI GPIO data register, replacing the generic traffic generator as the stage directly upstream of the GPIO slave. On each programmable tick it computes the next pattern, walking-one or binary count, and issues one AXI4-Lite write. It also reports completions, response errors and overruns.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clock cycles between pattern ticks; legal range ≥ 2.
- GPIO_BASE, 32'h0000_0000: GPIO slave base address.
- GPIO_W, 8: pattern width; legal range 1..32.

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- enable  in  1  run/stop.
- mode  in  1  0 = walking-one, 1 = binary count; sampled at tick.
- m_axi_lite_ch1_awaddr  out  32  write address.
- m_axi_lite_ch1_awprot  out  3  constant 3'b000.
- m_axi_lite_ch1_awvalid  out  1
- m_axi_lite_ch1_awready  in  1
- m_axi_lite_ch1_wdata  out  32  pattern, zero-extended.
- m_axi_lite_ch1_wstrb  out  4  constant 4'hF.
- m_axi_lite_ch1_wvalid  out  1
- m_axi_lite_ch1_wready  in  1
- m_axi_lite_ch1_bresp  in  2
- m_axi_lite_ch1_bvalid  in  1
- m_axi_lite_ch1_bready  out  1
- done  out  1  one-cycle pulse per completed write response.
- status  out  32  see Operation.

## Operation
- FSM states:
  - IDLE: on a pending tick, latch the next pattern, clear pending, go to ADDR.
  - ADDR: awvalid and wvalid asserted together; each drops independently on its own handshake; go to RESP when both have completed.
  - RESP: bready=1; on bvalid, pulse done, increment count, go to IDLE.
- Tick generator:
  - Counts 0..TICK_DIV-1 while enable=1; held at 0 while enable=0.
  - At terminal count it sets pending.
  - A terminal count while pending is already set sets sticky overrun; only one tick is ever queued.
- Pattern register (GPIO_W bits), reset value 0:
  - Walking-one: 0 → 1; otherwise rotate left, MSB wraps to bit 0.
  - Count: +1 modulo 2^GPIO_W.
- Address and data:
  - awaddr = GPIO_BASE + 0x000.
  - awaddr and wdata stay stable while the corresponding valid is high.
  - Valids never depend on ready.
- enable falling: the in-flight transaction completes normally; pending is cleared; the pattern is retained.
- bresp ≠ 2'b00: sets sticky err. The transaction still completes, and count and done still update.
- status fields:
  - [31] err.
  - [30] overrun.
  - [29:24] zero.
  - [23:16] last written pattern (low 8 bits).
  - [15:0] completed-write count, wraps 0xFFFF→0.
- Sticky bits clear only on reset.

## Timing
- Reset values: all AXI valids, bready, done, status, pattern, count, pending = 0; FSM state is IDLE.
- Reset asserted mid-transaction: all outputs return to reset values immediately, with no handshake completion. The GPIO slave shares this reset.
- Tick to issue latency: pending set on the terminal-count cycle; awvalid/wvalid rise on the next edge if the FSM is in IDLE.
- Ready inputs already high when valids rise: each channel completes in 1 cycle; ADDR lasts one cycle.
- bvalid already high on RESP entry: done pulses on the cycle after ADDR exit.
- bready is asserted only in RESP, never earlier.
- done pulse and status count/pattern update are registered on the same edge.
- Simultaneous terminal count and FSM leaving RESP: pending is set and the next transaction starts on the following IDLE cycle; no overrun.

## Configuration
- Macro LED_SEQ_TRI_INIT_EN.
- Defined:
  - After reset, the first transaction (issued once enable=1, with no tick required) writes 32'h0 to GPIO_BASE+0x004, the tri-state register.
  - Pattern writes begin only after its response.
  - It counts in status[15:0] and pulses done.
- Undefined: no tri-state write; the first transaction is the first pattern.

## Structure
- Package led_seq_pkg holds:
  - FSM state enum, including INIT, used only under the macro.
  - Mode enum.
  - GPIO_DATA_OFFSET=9'h000 and GPIO_TRI_OFFSET=9'h004.
  - AXI_RESP_OKAY=2'b00.
- Sub-module led_seq_tick_gen: divider counter plus pending/overrun logic.

## Test plan
- TICK_DIV=4, mode=0, zero-wait slave, enable=1 → wdata sequence 0x01, 0x02, …, 0x80, 0x01; awaddr=0x0 each time; done pulses every 4 cycles.
- mode=1, 300 ticks → wdata wraps 0xFF→0x00; status[15:0]=300.
- Slave delays awready 3 cycles and wready 0 cycles → awvalid held high with awaddr stable; wvalid drops after 1 cycle; a single done per write.
- Slave holds bvalid low 10 cycles with TICK_DIV=4 → status[30]=1; exactly one queued tick issued afterwards.
- bresp=2'b10 on one write → status[31]=1 stays set; count still increments.
- Reset asserted during ADDR → awvalid, wvalid, bready, status all 0 immediately. With LED_SEQ_TRI_INIT_EN, the first write after reset goes to 0x004 with data 0.
